// File: rtl/pipe_pkg.sv
// Shared definitions for rv64 inter-stage registers: occupancy state encoding,
// default payload widths per boundary and payload field offsets for callers.
package pipe_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_FULL  = 2'd1,
      PS_BUSY  = 2'd2
   } pipe_state_e;

   localparam int IF_ID_W  = 96;
   localparam int ID_EX_W  = 256;
   localparam int EX_MEM_W = 192;
   localparam int MEM_WB_W = 128;

   // Payload layout, LSB first; callers pack/unpack with these.
   localparam int PC_LSB      = 0;
   localparam int PC_W        = 64;
   localparam int RD_LSB      = 64;
   localparam int RD_W        = 5;
   localparam int REG_WEN_BIT = 69;
   localparam int OPCODE_LSB  = 70;
   localparam int OPCODE_W    = 7;
   localparam int ALU_OP_LSB  = 77;
   localparam int ALU_OP_W    = 4;
   localparam int LS_OP_LSB   = 81;
   localparam int LS_OP_W     = 4;
   localparam int BR_OP_LSB   = 85;
   localparam int BR_OP_W     = 3;
   localparam int COMMIT_LSB  = 88;
   localparam int COMMIT_W    = 64;

endpackage

// File: rtl/pipe_skid_buf.sv
// Main + skid register pair with registered in_ready, so upstream never sees
// a combinational path from out_ready.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              rdy_q;
   logic              in_xfer;

   assign in_xfer = in_valid & rdy_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         PS_EMPTY: begin
            if (in_xfer) begin
               state_d = PS_FULL;
               main_d  = in_data;
            end
         end
         PS_FULL: begin
            if (in_xfer && out_ready) begin
               main_d = in_data;
            end else if (in_xfer) begin
               state_d = PS_BUSY;
               skid_d  = in_data;
            end else if (out_ready) begin
               state_d = PS_EMPTY;
            end
         end
         PS_BUSY: begin
            if (out_ready) begin
               state_d = PS_FULL;
               main_d  = skid_q;
            end
         end
         default: state_d = PS_EMPTY;
      endcase
      // Flush drops occupancy only; held data stays put.
      if (flush) begin
         state_d = PS_EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PS_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= (state_d != PS_BUSY);
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q != PS_EMPTY);
   assign out_data  = main_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid/ready handshake, flush,
// optional skid buffer and a saturating stall counter.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 256,
   parameter int SKID   = 0,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   generate
      if (SKID != 0) begin : g_skid
         pipe_skid_buf #(
            .DATA_W(DATA_W)
         ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (out_data)
         );
      end else begin : g_reg
         pipe_state_e       state_q, state_d;
         logic [DATA_W-1:0] data_q, data_d;
         logic              rdy;

         // Single entry: free slot this cycle if empty or draining.
         assign rdy = (state_q == PS_EMPTY) | out_ready;

         always_comb begin
            state_d = state_q;
            data_d  = data_q;
            if (flush) begin
               state_d = PS_EMPTY;
            end else if (in_valid && rdy) begin
               state_d = PS_FULL;
               data_d  = in_data;
            end else if (out_ready) begin
               state_d = PS_EMPTY;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               state_q <= PS_EMPTY;
               data_q  <= '0;
            end else begin
               state_q <= state_d;
               data_q  <= data_d;
            end
         end

         assign in_ready  = rdy;
         assign out_valid = (state_q == PS_FULL);
         assign out_data  = data_q;
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign cnt_d = (out_valid && !out_ready) ? sat_inc(cnt_q) : cnt_q;

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one SKID=0 instance and one SKID=1
// instance with a 3-bit stall counter, sharing clock and reset.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst;

   logic        fl0, iv0, ir0, ov0, or0;
   logic [15:0] id0, od0;
   logic [7:0]  sc0;

   logic        fl1, iv1, ir1, ov1, or1;
   logic [15:0] id1, od1;
   logic [2:0]  sc1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .SKID(0), .CNT_W(8)) u_d0 (
      .clk(clk), .rst(rst), .flush(fl0),
      .in_valid(iv0), .in_ready(ir0), .in_data(id0),
      .out_valid(ov0), .out_ready(or0), .out_data(od0),
      .stall_cnt(sc0)
   );

   pipe_stage_reg #(.DATA_W(16), .SKID(1), .CNT_W(3)) u_d1 (
      .clk(clk), .rst(rst), .flush(fl1),
      .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .out_valid(ov1), .out_ready(or1), .out_data(od1),
      .stall_cnt(sc1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      fl0 = 1'b0; iv0 = 1'b1; id0 = 16'hABCD; or0 = 1'b0;
      fl1 = 1'b0; iv1 = 1'b1; id1 = 16'hABCD; or1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; iv0 = 1'b0; iv1 = 1'b0;
      #1;
      chk("rst_ov0", 32'(ov0), 32'd0);
      chk("rst_od0", 32'(od0), 32'd0);
      chk("rst_sc0", 32'(sc0), 32'd0);
      chk("rst_ir0", 32'(ir0), 32'd1);
      chk("rst_ov1", 32'(ov1), 32'd0);
      chk("rst_od1", 32'(od1), 32'd0);
      chk("rst_sc1", 32'(sc1), 32'd0);
      chk("rst_ir1", 32'(ir1), 32'd1);

      // Streaming 1..16 back-to-back on both instances
      or0 = 1'b1; or1 = 1'b1; iv0 = 1'b1; iv1 = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         id0 = 16'(i); id1 = 16'(i);
         #1;
         chk("str_ir0", 32'(ir0), 32'd1);
         chk("str_ir1", 32'(ir1), 32'd1);
         chk("str_ov0", 32'(ov0), 32'(i > 1));
         chk("str_ov1", 32'(ov1), 32'(i > 1));
         if (i > 1) begin
            chk("str_od0", 32'(od0), 32'(i - 1));
            chk("str_od1", 32'(od1), 32'(i - 1));
         end
         tick();
      end
      iv0 = 1'b0; iv1 = 1'b0;
      #1;
      chk("str_last_od0", 32'(od0), 32'd16);
      chk("str_last_od1", 32'(od1), 32'd16);
      tick();
      #1;
      chk("str_drain_ov0", 32'(ov0), 32'd0);
      chk("str_drain_ov1", 32'(ov1), 32'd0);
      chk("str_sc1", 32'(sc1), 32'd0);

      // SKID=1 back-pressure: A, B, C with out_ready low
      or1 = 1'b0; iv1 = 1'b1; id1 = 16'h000A;
      #1; chk("bp1_a_ir", 32'(ir1), 32'd1);
      tick();
      id1 = 16'h000B;
      #1;
      chk("bp1_b_ir", 32'(ir1), 32'd1);
      chk("bp1_b_od", 32'(od1), 32'h000A);
      tick();
      id1 = 16'h000C;
      #1;
      chk("bp1_busy_ir", 32'(ir1), 32'd0);
      chk("bp1_busy_ov", 32'(ov1), 32'd1);
      chk("bp1_busy_od", 32'(od1), 32'h000A);
      chk("bp1_busy_sc", 32'(sc1), 32'd1);
      tick();
      or1 = 1'b1;
      #1;
      chk("bp1_hold_ir", 32'(ir1), 32'd0);
      chk("bp1_hold_od", 32'(od1), 32'h000A);
      chk("bp1_hold_sc", 32'(sc1), 32'd2);
      tick();
      #1;
      chk("bp1_b_out_ir", 32'(ir1), 32'd1);
      chk("bp1_b_out_od", 32'(od1), 32'h000B);
      tick();
      iv1 = 1'b0;
      #1;
      chk("bp1_c_out_ov", 32'(ov1), 32'd1);
      chk("bp1_c_out_od", 32'(od1), 32'h000C);
      tick();
      #1;
      chk("bp1_empty_ov", 32'(ov1), 32'd0);
      chk("bp1_stall_sc", 32'(sc1), 32'd2);

      // SKID=0 back-pressure: in_ready follows out_ready in the same cycle
      iv0 = 1'b1; id0 = 16'h0055; or0 = 1'b1;
      tick();
      iv0 = 1'b0; or0 = 1'b0;
      #1;
      chk("bp0_ov", 32'(ov0), 32'd1);
      chk("bp0_ir_low", 32'(ir0), 32'd0);
      tick();
      id0 = 16'h1234;
      #1;
      chk("bp0_sc", 32'(sc0), 32'd1);
      chk("bp0_idle_od", 32'(od0), 32'h0055);
      or0 = 1'b1;
      #1;
      chk("bp0_ir_high", 32'(ir0), 32'd1);
      tick();
      #1;
      chk("bp0_drain_ov", 32'(ov0), 32'd0);

      // SKID=0 flush discards an accepted input and keeps out_data
      iv0 = 1'b1; id0 = 16'h0077; fl0 = 1'b1;
      tick();
      iv0 = 1'b0; fl0 = 1'b0;
      #1;
      chk("fl0_ov", 32'(ov0), 32'd0);
      chk("fl0_od_kept", 32'(od0), 32'h0055);

      // SKID=1 flush from BUSY with C offered
      or1 = 1'b0; iv1 = 1'b1; id1 = 16'h00A1;
      tick();
      id1 = 16'h00B1;
      tick();
      id1 = 16'h00C1; fl1 = 1'b1;
      #1; chk("fl1_busy_ir", 32'(ir1), 32'd0);
      tick();
      fl1 = 1'b0; iv1 = 1'b0;
      #1;
      chk("fl1_ov", 32'(ov1), 32'd0);
      chk("fl1_ir", 32'(ir1), 32'd1);
      chk("fl1_sc", 32'(sc1), 32'd4);
      iv1 = 1'b1; id1 = 16'h00E1; fl1 = 1'b1;
      tick();
      fl1 = 1'b0; iv1 = 1'b0;
      #1; chk("fl1_drop_ov", 32'(ov1), 32'd0);
      iv1 = 1'b1; id1 = 16'h00D1; or1 = 1'b1;
      tick();
      iv1 = 1'b0;
      #1;
      chk("fl1_d_ov", 32'(ov1), 32'd1);
      chk("fl1_d_od", 32'(od1), 32'h00D1);
      tick();
      #1; chk("fl1_d_gone", 32'(ov1), 32'd0);

      // Counter saturation: 4 + 10 stalls in a 3-bit counter
      iv1 = 1'b1; id1 = 16'h0099; or1 = 1'b0;
      tick();
      iv1 = 1'b0;
      repeat (10) tick();
      #1;
      chk("sat_sc", 32'(sc1), 32'd7);
      chk("sat_ov", 32'(ov1), 32'd1);
      tick();
      #1; chk("sat_hold", 32'(sc1), 32'd7);

      // Reset mid-stall
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst2_sc1", 32'(sc1), 32'd0);
      chk("rst2_ov1", 32'(ov1), 32'd0);
      chk("rst2_ir1", 32'(ir1), 32'd1);
      chk("rst2_sc0", 32'(sc0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
